// File: rtl/updown_cmd_pkg.sv
// Shared types and constants for the up/down command queue.
//   cmd_state_t : issue FSM states (IDLE, STROBE, SPACE)
//   DIR_UP/DOWN : command direction encoding (1 = up -> en, 0 = down -> ds)
//   ISSUED_W    : width of the issued-strobe counter
//   GAP_W       : width of the inter-strobe gap counter (GAP range 0..15)
package updown_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    SPACE  = 2'd2
  } cmd_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int ISSUED_W = 16;
  localparam int GAP_W    = 4;

endpackage

// File: rtl/updown_cmd_queue_fifo.sv
// cmd_fifo: 1-bit-wide synchronous FIFO holding queued command directions.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push, din  : write din at the tail (caller guarantees !full)
//   pop, dout  : advance the head (caller guarantees !empty); dout shows head
//   clear      : synchronous clear of all entries (wins over push/pop)
//   full/empty : status from the registered pointers
//   level      : number of stored entries
// Pointers carry one extra MSB: equal pointers mean empty, pointers that
// differ only in the MSB mean full.
module cmd_fifo #(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          din,
  output logic          dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level,
  input  logic          clear
);

  logic [AW:0]      wr_q, rd_q;
  logic [DEPTH-1:0] mem_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (clear) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign level = LW'(wr_q - rd_q);

endmodule

// File: rtl/updown_cmd_queue.sv
// updown_cmd_queue: buffers up/down commands and issues each one as a
// single-cycle, mutually exclusive en (up) / ds (down) strobe for the
// downstream modulo-12 counter.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   cmd_valid, cmd_dir  : command input (cmd_dir 1 = up, 0 = down)
//   cmd_ready           : !full && !flush
//   hold                : blocks new pops (never cuts a strobe short)
//   flush               : synchronous clear of queue, FSM and strobes
//   en, ds              : registered one-cycle strobes
//   level               : queued entries
//   issued              : strobes issued so far (wraps)
//   dbg_state           : current FSM state (cmd_state_t encoding)
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high; the source keeps cmd_valid/cmd_dir stable until
// then. cmd_ready depends only on the registered full flag and flush.
module updown_cmd_queue
  import updown_cmd_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int GAP   = 0,
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  input  logic                cmd_dir,
  output logic                cmd_ready,
  input  logic                hold,
  input  logic                flush,
  output logic                en,
  output logic                ds,
  output logic [LW-1:0]       level,
  output logic [ISSUED_W-1:0] issued,
  output logic [1:0]          dbg_state
);

  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

  cmd_state_t          state_q, state_d;
  logic [GAP_W-1:0]    gap_q, gap_d;
  logic                en_q, en_d, ds_q, ds_d;
  logic [ISSUED_W-1:0] issued_q, issued_d;

  logic fifo_full, fifo_empty, fifo_dout;
  logic push, pop, pop_ok;

  assign cmd_ready = !fifo_full && !flush;
  assign push      = cmd_valid && cmd_ready;
  assign pop_ok    = !fifo_empty && !hold && !flush;

  cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (cmd_dir),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level),
    .clear (flush)
  );

  // A pop decided this cycle becomes the strobe of the next cycle, so the
  // strobe registers load from the head entry at the popping edge.
  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    pop      = 1'b0;
    issued_d = issued_q;

    if (state_q == STROBE) issued_d = issued_q + 1'b1;

    if (flush) begin
      state_d = IDLE;
      gap_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pop_ok) begin
            pop     = 1'b1;
            state_d = STROBE;
          end
        end
        STROBE: begin
          if (GAP > 0) begin
            state_d = SPACE;
            gap_d   = GAP_LOAD;
          end else if (pop_ok) begin
            pop     = 1'b1;
            state_d = STROBE;
          end else begin
            state_d = IDLE;
          end
        end
        SPACE: begin
          // The gap keeps counting while hold is high; hold only gates the pop.
          if (gap_q == '0) begin
            if (pop_ok) begin
              pop     = 1'b1;
              state_d = STROBE;
            end else begin
              state_d = IDLE;
            end
          end else begin
            gap_d = gap_q - 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    en_d = pop && (fifo_dout == DIR_UP);
    ds_d = pop && (fifo_dout == DIR_DOWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      gap_q    <= '0;
      en_q     <= 1'b0;
      ds_q     <= 1'b0;
      issued_q <= '0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      en_q     <= en_d;
      ds_q     <= ds_d;
      issued_q <= issued_d;
    end
  end

  assign en        = en_q;
  assign ds        = ds_q;
  assign issued    = issued_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_updown_cmd_queue.sv
// Bench for updown_cmd_queue: u_dut (GAP=0) is checked by a scoreboard of
// accepted directions plus directed timing vectors; u_gap (GAP=2) checks
// strobe spacing.
module tb_updown_cmd_queue;
  import updown_cmd_pkg::*;

  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (GAP = 0) ----------------
  logic        cmd_valid, cmd_dir, cmd_ready, hold, flush, en, ds;
  logic [2:0]  level;
  logic [15:0] issued;
  logic [1:0]  st;

  updown_cmd_queue #(.DEPTH(DEPTH), .GAP(0)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .hold(hold), .flush(flush), .en(en), .ds(ds),
    .level(level), .issued(issued), .dbg_state(st)
  );

  // ---------------- DUT (GAP = 2) ----------------
  logic        g_valid, g_dir, g_ready, g_hold, g_flush, g_en, g_ds;
  logic [2:0]  g_level;
  logic [15:0] g_issued;
  logic [1:0]  g_st;

  updown_cmd_queue #(.DEPTH(DEPTH), .GAP(2)) u_gap (
    .clk(clk), .rst(rst), .cmd_valid(g_valid), .cmd_dir(g_dir),
    .cmd_ready(g_ready), .hold(g_hold), .flush(g_flush), .en(g_en), .ds(g_ds),
    .level(g_level), .issued(g_issued), .dbg_state(g_st)
  );

  // ---------------- scoreboard state ----------------
  int         n_total = 0;
  int         n_bad = 0;
  int         n_acc = 0;
  int         n_flushed = 0;
  logic [0:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the inputs currently driven; records acceptance/flush.
  task automatic step(output bit acc_o);
    bit a, f;
    #1;
    a = cmd_valid && cmd_ready;
    f = flush;
    @(posedge clk);
    if (f) begin
      n_flushed += exp_q.size();
      exp_q.delete();
    end
    if (a) begin
      exp_q.push_back(cmd_dir);
      n_acc++;
    end
    #1;
    acc_o = a;
  endtask

  task automatic push_cmd(input logic d);
    bit a;
    cmd_valid = 1'b1;
    cmd_dir   = d;
    step(a);
    cmd_valid = 1'b0;
    chk("push_accepted", 32'(a), 32'd1);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [0:0] d;
    if (!rst) begin
      chk("excl_en_ds", 32'(en && ds), 32'd0);
      if (en || ds) begin
        if (exp_q.size() == 0) begin
          n_total++;
          n_bad++;
          $display("FAIL order: strobe en=%0b ds=%0b with nothing expected", en, ds);
        end else begin
          d = exp_q.pop_front();
          chk("order_dir", 32'(en), 32'(d));
        end
      end
      chk("level_vs_sb", 32'(level), 32'(exp_q.size()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit a;
    logic [8:0] pat;
    logic [4:0] dirs;

    rst = 1'b1;
    cmd_valid = 0; cmd_dir = 0; hold = 0; flush = 0;
    g_valid = 0; g_dir = 0; g_hold = 0; g_flush = 0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("rst_en", 32'(en), 32'd0);
    chk("rst_ds", 32'(ds), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_issued", 32'(issued), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_state", 32'(st), 32'(IDLE));

    // up, up, down back to back at GAP=0
    cmd_valid = 1; cmd_dir = 1; step(a);
    chk("t1_k0_en", 32'(en), 0); chk("t1_k0_lvl", 32'(level), 1);
    cmd_dir = 1; step(a);
    chk("t1_k1_en", 32'(en), 1); chk("t1_k1_lvl", 32'(level), 1);
    cmd_dir = 0; step(a);
    chk("t1_k2_en", 32'(en), 1); chk("t1_k2_lvl", 32'(level), 1);
    cmd_valid = 0; tick();
    chk("t1_k3_en", 32'(en), 0); chk("t1_k3_ds", 32'(ds), 1);
    chk("t1_k3_lvl", 32'(level), 0);
    tick();
    chk("t1_k4_ds", 32'(ds), 0); chk("t1_issued", 32'(issued), 3);

    // GAP=2 on the second instance: three ups
    pat = 9'b0_1001_0010;  // bit i = expected en after edge k_i
    g_valid = 1; g_dir = 1;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 2) g_valid = 0;
      chk("gap_en", 32'(g_en), 32'(pat[i]));
      chk("gap_ds", 32'(g_ds), 0);
    end
    chk("gap_issued", 32'(g_issued), 3);
    chk("gap_level", 32'(g_level), 0);

    // fill under hold, 5th command waits for a free slot
    dirs = 5'b01101;  // issue order: bit0 first
    hold = 1;
    for (int i = 0; i < 4; i++) push_cmd(dirs[i]);
    chk("full_lvl", 32'(level), 4);
    chk("full_ready", 32'(cmd_ready), 0);
    cmd_valid = 1; cmd_dir = dirs[4]; hold = 0;
    step(a);
    chk("full_5th_refused", 32'(a), 0);
    chk("full_pop_lvl", 32'(level), 3);
    chk("full_pop_ready", 32'(cmd_ready), 1);
    chk("full_pop_en", 32'(en), 1);
    step(a);
    chk("full_5th_taken", 32'(a), 1);
    chk("full_pushpop_lvl", 32'(level), 3);
    cmd_valid = 0;
    repeat (10) tick();
    chk("full_drained", 32'(exp_q.size()), 0);
    chk("full_issued", 32'(issued), 8);

    // flush with three queued and a command offered
    hold = 1;
    push_cmd(0); push_cmd(1); push_cmd(0);
    chk("fl_lvl3", 32'(level), 3);
    flush = 1; cmd_valid = 1; cmd_dir = 1;
    #1;
    chk("fl_ready", 32'(cmd_ready), 0);
    step(a);
    chk("fl_refused", 32'(a), 0);
    chk("fl_lvl", 32'(level), 0);
    chk("fl_en", 32'(en), 0);
    chk("fl_ds", 32'(ds), 0);
    chk("fl_issued", 32'(issued), 8);
    flush = 0; cmd_valid = 0; hold = 0;
    repeat (3) tick();
    chk("fl_after_lvl", 32'(level), 0);
    chk("fl_after_issued", 32'(issued), 8);

    // reset in the middle of a strobe
    hold = 1;
    push_cmd(1); push_cmd(1); push_cmd(0);
    hold = 0;
    step(a);
    chk("rs_pre_en", 32'(en), 1);
    chk("rs_pre_lvl", 32'(level), 2);
    rst = 1;
    exp_q.delete(); n_acc = 0; n_flushed = 0;
    #1;
    chk("rs_en", 32'(en), 0);
    chk("rs_ds", 32'(ds), 0);
    chk("rs_lvl", 32'(level), 0);
    chk("rs_issued", 32'(issued), 0);
    tick(); tick();
    rst = 0;
    cmd_valid = 1; cmd_dir = 0; step(a);
    cmd_valid = 0;
    chk("rs_k0_ds", 32'(ds), 0); chk("rs_k0_lvl", 32'(level), 1);
    tick();
    chk("rs_k1_ds", 32'(ds), 1); chk("rs_k1_lvl", 32'(level), 0);
    tick();
    chk("rs_k2_ds", 32'(ds), 0); chk("rs_issued1", 32'(issued), 1);

    // random valid/dir/hold with occasional flush
    a = 1;
    for (int c = 0; c < 10000; c++) begin
      if (!cmd_valid || a) begin
        cmd_valid = ($urandom_range(0, 99) < 60);
        cmd_dir   = 1'($urandom_range(0, 1));
      end
      hold  = ($urandom_range(0, 99) < 30);
      flush = ($urandom_range(0, 99) < 3);
      step(a);
    end
    cmd_valid = 0; hold = 0; flush = 0;
    repeat (20) tick();
    chk("rnd_drained", 32'(exp_q.size()), 0);
    chk("rnd_issued", 32'(issued), 32'(16'(n_acc - n_flushed)));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
